mem_port_arbiter: RTL and testbench

Sequencer and arbiter for the CPU's single memory port, shared by instruction fetch (IF) and load/store/stack traffic (LS: push, pop, call, ret). Each requester holds a request until the arbiter returns a one-cycle done pulse. The arbiter drives registered memory strobes and tolerates variable-latency memory via mem_ready. A stalled access is aborted by a wait-state timeout. It sits between the controller/datapath and the data/stack memory and replaces the fixed read/write strobes of the single-cycle controller.

---
 rtl/mem_port_arbiter.sv | 151 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Arbiter and sequencer for the shared CPU memory port: instruction fetch vs.
// load/store traffic, with registered strobes, variable latency and wait-state abort.
module mem_port_arbiter #(
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 16,
  parameter int MAX_WAIT = 15
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_done,
  input  logic              ls_req,
  input  logic              ls_we,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [DATA_W-1:0] ls_wdata,
  output logic [DATA_W-1:0] ls_rdata,
  output logic              ls_done,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_read,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              err_timeout
);

  localparam int CNT_W = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(MAX_WAIT - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t            state_r;
  state_t            state_s;
  logic              owner_r;       // 1 = LS owns the port
  logic              last_owner_r;  // 1 = LS was granted last
  logic [CNT_W-1:0]  wait_cnt_r;
  logic              grant_s;
  logic              grant_ls_s;
  logic              finish_s;
  logic              timeout_s;

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic, grant selection and completion detection.
  always_comb begin
    state_s    = state_r;
    grant_s    = 1'b0;
    grant_ls_s = 1'b0;
    finish_s   = 1'b0;
    timeout_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (if_req && ls_req) begin
          grant_s    = 1'b1;
          grant_ls_s = ~last_owner_r;
        end else if (if_req) begin
          grant_s    = 1'b1;
          grant_ls_s = 1'b0;
        end else if (ls_req) begin
          grant_s    = 1'b1;
          grant_ls_s = 1'b1;
        end else begin
          grant_s    = 1'b0;
        end
        if (grant_s) begin
          state_s = ACCESS;
        end else begin
          state_s = IDLE;
        end
      end
      ACCESS: begin
        if (mem_ready) begin
          finish_s = 1'b1;
          state_s  = DONE;
        end else if (wait_cnt_r == LAST_WAIT) begin
          finish_s  = 1'b1;
          timeout_s = 1'b1;
          state_s   = DONE;
        end else begin
          state_s = ACCESS;
        end
      end
      DONE: begin
        // Requests are deliberately ignored here so requesters can drop req.
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Registered strobes, address/data, completion pulses and read data.
  always_ff @(posedge clock) begin
    if (reset) begin
      owner_r      <= 1'b0;
      last_owner_r <= 1'b1;
      wait_cnt_r   <= {CNT_W{1'b0}};
      mem_addr     <= {ADDR_W{1'b0}};
      mem_wdata    <= {DATA_W{1'b0}};
      mem_read     <= 1'b0;
      mem_write    <= 1'b0;
      if_done      <= 1'b0;
      ls_done      <= 1'b0;
      err_timeout  <= 1'b0;
      if_rdata     <= {DATA_W{1'b0}};
      ls_rdata     <= {DATA_W{1'b0}};
    end else begin
      if_done     <= finish_s & ~owner_r;
      ls_done     <= finish_s & owner_r;
      err_timeout <= timeout_s;
      if (grant_s) begin
        owner_r      <= grant_ls_s;
        last_owner_r <= grant_ls_s;
        wait_cnt_r   <= {CNT_W{1'b0}};
        mem_addr     <= grant_ls_s ? ls_addr : if_addr;
        mem_wdata    <= grant_ls_s ? ls_wdata : {DATA_W{1'b0}};
        mem_read     <= ~grant_ls_s | ~ls_we;
        mem_write    <= grant_ls_s & ls_we;
      end else if (finish_s) begin
        mem_read  <= 1'b0;
        mem_write <= 1'b0;
        if (mem_read && !owner_r) begin
          if_rdata <= timeout_s ? {DATA_W{1'b0}} : mem_rdata;
        end else if (mem_read && owner_r) begin
          ls_rdata <= timeout_s ? {DATA_W{1'b0}} : mem_rdata;
        end else begin
          if_rdata <= if_rdata;
        end
      end else if (state_r == ACCESS) begin
        wait_cnt_r <= wait_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        wait_cnt_r <= wait_cnt_r;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter: reset, fetch, contention,
// wait states, timeout and reset during an access.
module tb_mem_port_arbiter;

  logic        clock;
  logic        reset;
  logic        if_req;
  logic [15:0] if_addr;
  logic [15:0] if_rdata;
  logic        if_done;
  logic        ls_req;
  logic        ls_we;
  logic [15:0] ls_addr;
  logic [15:0] ls_wdata;
  logic [15:0] ls_rdata;
  logic        ls_done;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_read;
  logic        mem_write;
  logic [15:0] mem_rdata;
  logic        mem_ready;
  logic        err_timeout;

  int n_cmp;
  int n_bad;

  mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .MAX_WAIT(15)) dut (
    .clock(clock), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done),
    .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .ls_rdata(ls_rdata), .ls_done(ls_done),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_read(mem_read), .mem_write(mem_write),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .err_timeout(err_timeout)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; if_req = 1'b1; ls_req = 1'b1; ls_we = 1'b1;
    if_addr = 16'h0040; ls_addr = 16'h00FE; ls_wdata = 16'hBEEF;
    mem_ready = 1'b0; mem_rdata = 16'h1111;
    tick(); tick();
    n_cmp++; if ({mem_read, mem_write} !== 2'b00) begin n_bad++; $display("FAIL reset_strobes: got %b want 00", {mem_read, mem_write}); end
    n_cmp++; if ({if_done, ls_done, err_timeout} !== 3'b000) begin n_bad++; $display("FAIL reset_pulses: got %b want 000", {if_done, ls_done, err_timeout}); end
    n_cmp++; if ({mem_addr, mem_wdata} !== 32'h0) begin n_bad++; $display("FAIL reset_addr_data: got %h want 0", {mem_addr, mem_wdata}); end
    n_cmp++; if ({if_rdata, ls_rdata} !== 32'h0) begin n_bad++; $display("FAIL reset_rdata: got %h want 0", {if_rdata, ls_rdata}); end
    reset = 1'b0;
    tick();
    n_cmp++; if ({mem_read, mem_write} !== 2'b10) begin n_bad++; $display("FAIL reset_first_grant: got %b want 10", {mem_read, mem_write}); end
    n_cmp++; if (mem_addr !== 16'h0040) begin n_bad++; $display("FAIL reset_first_addr: got %h want 0040", mem_addr); end
    mem_ready = 1'b1;
    tick();
    n_cmp++; if ({if_done, ls_done} !== 2'b10) begin n_bad++; $display("FAIL reset_first_done: got %b want 10", {if_done, ls_done}); end
    if_req = 1'b0; ls_req = 1'b0; mem_ready = 1'b0;
    tick(); tick();
  endtask

  task automatic test_fetch();
    if_addr = 16'h0010; mem_rdata = 16'hA5A5; mem_ready = 1'b1; if_req = 1'b1;
    tick();
    n_cmp++; if ({mem_read, mem_addr} !== {1'b1, 16'h0010}) begin n_bad++; $display("FAIL fetch_strobe: got %b/%h want 1/0010", mem_read, mem_addr); end
    n_cmp++; if (if_done !== 1'b0) begin n_bad++; $display("FAIL fetch_early_done: got %b want 0", if_done); end
    tick();
    n_cmp++; if ({if_done, ls_done, mem_read} !== 3'b100) begin n_bad++; $display("FAIL fetch_done: got %b want 100", {if_done, ls_done, mem_read}); end
    n_cmp++; if (if_rdata !== 16'hA5A5) begin n_bad++; $display("FAIL fetch_rdata: got %h want a5a5", if_rdata); end
    if_req = 1'b0;
    tick();
    n_cmp++; if ({if_done, ls_done} !== 2'b00) begin n_bad++; $display("FAIL fetch_pulse_width: got %b want 00", {if_done, ls_done}); end
    mem_ready = 1'b0;
    tick();
  endtask

  task automatic test_contention();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    if_addr = 16'h0020; ls_we = 1'b1; ls_addr = 16'h00FE; ls_wdata = 16'hBEEF;
    mem_ready = 1'b1; mem_rdata = 16'h5555; if_req = 1'b1; ls_req = 1'b1;
    for (int k = 0; k < 4; k++) begin
      logic ls_slot;
      ls_slot = (k % 2) == 1;
      tick();
      n_cmp++; if ({mem_read, mem_write} !== {~ls_slot, ls_slot}) begin n_bad++; $display("FAIL contend_strobe_%0d: got %b want %b", k, {mem_read, mem_write}, {~ls_slot, ls_slot}); end
      n_cmp++; if (mem_addr !== (ls_slot ? 16'h00FE : 16'h0020)) begin n_bad++; $display("FAIL contend_addr_%0d: got %h", k, mem_addr); end
      if (ls_slot) begin
        n_cmp++; if (mem_wdata !== 16'hBEEF) begin n_bad++; $display("FAIL contend_wdata_%0d: got %h want beef", k, mem_wdata); end
      end
      tick();
      n_cmp++; if ({if_done, ls_done} !== {~ls_slot, ls_slot}) begin n_bad++; $display("FAIL contend_done_%0d: got %b want %b", k, {if_done, ls_done}, {~ls_slot, ls_slot}); end
      tick();
      n_cmp++; if ({if_done, ls_done, mem_read, mem_write} !== 4'b0000) begin n_bad++; $display("FAIL contend_gap_%0d: got %b want 0000", k, {if_done, ls_done, mem_read, mem_write}); end
    end
    n_cmp++; if ({if_rdata, ls_rdata} !== {16'h5555, 16'h0000}) begin n_bad++; $display("FAIL contend_rdata: got %h want 55550000", {if_rdata, ls_rdata}); end
    if_req = 1'b0; ls_req = 1'b0; mem_ready = 1'b0;
    tick();
  endtask

  task automatic test_wait_states();
    int high_cycles;
    high_cycles = 0;
    ls_req = 1'b1; ls_we = 1'b0; ls_addr = 16'h0100; mem_ready = 1'b0; mem_rdata = 16'hDEAD;
    tick();
    if (mem_read) high_cycles++;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (mem_read) high_cycles++;
      n_cmp++; if ({mem_addr, ls_done} !== {16'h0100, 1'b0}) begin n_bad++; $display("FAIL wait_hold_%0d: got %h/%b want 0100/0", i, mem_addr, ls_done); end
    end
    mem_ready = 1'b1; mem_rdata = 16'h1234;
    tick();
    if (mem_read) high_cycles++;
    n_cmp++; if (high_cycles !== 4) begin n_bad++; $display("FAIL wait_read_cycles: got %0d want 4", high_cycles); end
    n_cmp++; if ({ls_done, err_timeout} !== 2'b10) begin n_bad++; $display("FAIL wait_done: got %b want 10", {ls_done, err_timeout}); end
    n_cmp++; if (ls_rdata !== 16'h1234) begin n_bad++; $display("FAIL wait_rdata: got %h want 1234", ls_rdata); end
    ls_req = 1'b0; mem_ready = 1'b0;
    tick();
    n_cmp++; if (ls_done !== 1'b0) begin n_bad++; $display("FAIL wait_pulse_width: got %b want 0", ls_done); end
    tick();
  endtask

  task automatic test_timeout();
    if_req = 1'b1; if_addr = 16'h0030; mem_ready = 1'b0; mem_rdata = 16'hFFFF;
    tick();
    for (int i = 1; i < 15; i++) begin
      tick();
      n_cmp++; if ({mem_read, if_done, err_timeout} !== 3'b100) begin n_bad++; $display("FAIL timeout_wait_%0d: got %b want 100", i, {mem_read, if_done, err_timeout}); end
    end
    tick();
    n_cmp++; if ({mem_read, if_done, err_timeout} !== 3'b011) begin n_bad++; $display("FAIL timeout_abort: got %b want 011", {mem_read, if_done, err_timeout}); end
    n_cmp++; if (if_rdata !== 16'h0000) begin n_bad++; $display("FAIL timeout_rdata: got %h want 0000", if_rdata); end
    if_req = 1'b0;
    tick();
    n_cmp++; if ({if_done, err_timeout} !== 2'b00) begin n_bad++; $display("FAIL timeout_pulse_width: got %b want 00", {if_done, err_timeout}); end
    ls_req = 1'b1; ls_we = 1'b0; ls_addr = 16'h0200; mem_ready = 1'b1; mem_rdata = 16'h7777;
    tick();
    n_cmp++; if ({mem_read, mem_addr} !== {1'b1, 16'h0200}) begin n_bad++; $display("FAIL timeout_next_grant: got %b/%h want 1/0200", mem_read, mem_addr); end
    tick();
    n_cmp++; if ({ls_done, err_timeout, ls_rdata} !== {2'b10, 16'h7777}) begin n_bad++; $display("FAIL timeout_next_done: got %b%b/%h want 10/7777", ls_done, err_timeout, ls_rdata); end
    ls_req = 1'b0; mem_ready = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_access();
    ls_req = 1'b1; ls_we = 1'b1; ls_addr = 16'h0300; ls_wdata = 16'hCAFE; mem_ready = 1'b0;
    tick();
    n_cmp++; if ({mem_write, mem_wdata} !== {1'b1, 16'hCAFE}) begin n_bad++; $display("FAIL rmid_write: got %b/%h want 1/cafe", mem_write, mem_wdata); end
    tick();
    reset = 1'b1;
    tick();
    n_cmp++; if ({mem_write, mem_read, ls_done} !== 3'b000) begin n_bad++; $display("FAIL rmid_abort: got %b want 000", {mem_write, mem_read, ls_done}); end
    reset = 1'b0; if_req = 1'b1; if_addr = 16'h0044; ls_we = 1'b0;
    tick();
    n_cmp++; if ({mem_read, mem_write, mem_addr} !== {2'b10, 16'h0044}) begin n_bad++; $display("FAIL rmid_if_first: got %b%b/%h want 10/0044", mem_read, mem_write, mem_addr); end
    n_cmp++; if (ls_done !== 1'b0) begin n_bad++; $display("FAIL rmid_no_done: got %b want 0", ls_done); end
    mem_ready = 1'b1;
    tick();
    n_cmp++; if ({if_done, ls_done} !== 2'b10) begin n_bad++; $display("FAIL rmid_done: got %b want 10", {if_done, ls_done}); end
    if_req = 1'b0; ls_req = 1'b0; mem_ready = 1'b0;
    tick();
  endtask

  initial begin
    n_cmp = 0; n_bad = 0;
    reset = 1'b1; if_req = 1'b0; ls_req = 1'b0; ls_we = 1'b0;
    if_addr = 16'h0; ls_addr = 16'h0; ls_wdata = 16'h0; mem_rdata = 16'h0; mem_ready = 1'b0;
    test_reset();
    test_fetch();
    test_contention();
    test_wait_states();
    test_timeout();
    test_reset_mid_access();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
